// File: rtl/router_pkt_fifo.sv
// Packet FIFO for one router output channel: tags header words and decodes packet length on the read side.
// Optional sticky error output is enabled by defining ROUTER_FIFO_ERR_EN.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              pkt_done,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
`ifdef ROUTER_FIFO_ERR_EN
    output logic              err,
`endif
    output logic [ADDR_W:0]   fill_level
);

    // Count holds payload length plus parity, so it needs one bit more than the length field.
    localparam int CNT_W = DATA_W - 1;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              lfd_q, lfd_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              pkt_done_q, pkt_done_d;
    logic              err_q, err_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W:0]   rd_word;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign fill_level  = wr_ptr_q - rd_ptr_q;
    assign almost_full = (fill_level >= (ADDR_W+1)'(AFULL_TH));
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign pkt_done    = pkt_done_q;
`ifdef ROUTER_FIFO_ERR_EN
    assign err         = err_q;
`endif

    assign wr_ok   = wr_en && !full && !soft_rst;
    assign rd_ok   = rd_en && !empty;
    assign rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lfd_d        = lfd_state;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        err_d        = err_q | (wr_en && full) | (rd_en && empty);
        if (soft_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            lfd_d    = 1'b0;
            dout_d   = '0;
            err_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                dout_d       = rd_word[DATA_W-1:0];
                dout_valid_d = 1'b1;
                // A header always restarts the count, even mid-packet.
                if (rd_word[DATA_W]) begin
                    count_d = CNT_W'(rd_word[DATA_W-1:2]) + CNT_W'(1);
                end else if (count_q != '0) begin
                    count_d    = count_q - CNT_W'(1);
                    pkt_done_d = (count_q == CNT_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lfd_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lfd_q        <= lfd_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            pkt_done_q   <= pkt_done_d;
            err_q        <= err_d;
        end
    end

    // Storage is not reset; stale contents are never visible because the pointers are.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_q, d_in};
        end
    end

`ifndef ROUTER_FIFO_ERR_EN
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo (DEPTH=16, DATA_W=8).
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       pkt_done;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] fill_level;
`ifdef ROUTER_FIFO_ERR_EN
    logic       err;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AFULL_TH(14)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .rd_en(rd_en),
        .lfd_state(lfd_state), .d_in(d_in), .dout(dout), .dout_valid(dout_valid),
        .pkt_done(pkt_done), .full(full), .empty(empty), .almost_full(almost_full),
`ifdef ROUTER_FIFO_ERR_EN
        .err(err),
`endif
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total_cnt++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %0h expected 0", dout); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0) $display("[TB] FAIL reset_dout_valid: got %0b expected 0", dout_valid); else pass_cnt++;
        total_cnt++; if (pkt_done !== 1'b0) $display("[TB] FAIL reset_pkt_done: got %0b expected 0", pkt_done); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %0b expected 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %0b expected 0", full); else pass_cnt++;
        total_cnt++; if (almost_full !== 1'b0) $display("[TB] FAIL reset_afull: got %0b expected 0", almost_full); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd0) $display("[TB] FAIL reset_fill: got %0d expected 0", fill_level); else pass_cnt++;
`ifdef ROUTER_FIFO_ERR_EN
        total_cnt++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %0b expected 0", err); else pass_cnt++;
`endif
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = 8'hC0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++; if (dout !== 8'hC0 || dout_valid !== 1'b1) $display("[TB] FAIL arst_pre_read: got %0h/%0b expected c0/1", dout, dout_valid); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd2) $display("[TB] FAIL arst_pre_fill: got %0d expected 2", fill_level); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if (fill_level !== 5'd0 || empty !== 1'b1) $display("[TB] FAIL arst_fill_empty: got %0d/%0b expected 0/1", fill_level, empty); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00 || dout_valid !== 1'b0) $display("[TB] FAIL arst_dout: got %0h/%0b expected 0/0", dout, dout_valid); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_packet();
        logic [7:0] exp_words [5];
        exp_words = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_in = exp_words[i];
            tick();
        end
        wr_en = 1'b0;
        total_cnt++; if (fill_level !== 5'd5) $display("[TB] FAIL pkt_fill: got %0d expected 5", fill_level); else pass_cnt++;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (dout !== exp_words[i] || dout_valid !== 1'b1) $display("[TB] FAIL pkt_dout%0d: got %0h/%0b expected %0h/1", i, dout, dout_valid, exp_words[i]); else pass_cnt++;
            total_cnt++; if (pkt_done !== (i == 4)) $display("[TB] FAIL pkt_done%0d: got %0b expected %0b", i, pkt_done, (i == 4)); else pass_cnt++;
        end
        rd_en = 1'b0;
        tick();
        total_cnt++; if (dout !== 8'h5E || dout_valid !== 1'b0 || pkt_done !== 1'b0) $display("[TB] FAIL pkt_idle: got %0h/%0b/%0b expected 5e/0/0", dout, dout_valid, pkt_done); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL pkt_empty: got %0b expected 1", empty); else pass_cnt++;
    endtask

    task automatic test_full();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_in = 8'h10 + 8'(i);
            tick();
            if (i == 0) begin
                total_cnt++; if (empty !== 1'b0) $display("[TB] FAIL full_first_empty: got %0b expected 0", empty); else pass_cnt++;
            end
            total_cnt++; if (fill_level !== 5'(i + 1)) $display("[TB] FAIL full_fill%0d: got %0d expected %0d", i, fill_level, i + 1); else pass_cnt++;
            total_cnt++; if (almost_full !== (i + 1 >= 14)) $display("[TB] FAIL full_afull%0d: got %0b expected %0b", i, almost_full, (i + 1 >= 14)); else pass_cnt++;
            total_cnt++; if (full !== (i == 15)) $display("[TB] FAIL full_flag%0d: got %0b expected %0b", i, full, (i == 15)); else pass_cnt++;
        end
        d_in = 8'hFF;
        tick();
        wr_en = 1'b0;
        total_cnt++; if (fill_level !== 5'd16 || full !== 1'b1) $display("[TB] FAIL full_drop: got %0d/%0b expected 16/1", fill_level, full); else pass_cnt++;
`ifdef ROUTER_FIFO_ERR_EN
        total_cnt++; if (err !== 1'b1) $display("[TB] FAIL full_err: got %0b expected 1", err); else pass_cnt++;
`endif
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total_cnt++; if (dout !== 8'h10 + 8'(i)) $display("[TB] FAIL full_read%0d: got %0h expected %0h", i, dout, 8'h10 + 8'(i)); else pass_cnt++;
        end
        rd_en = 1'b0;
        tick();
        total_cnt++; if (empty !== 1'b1 || fill_level !== 5'd0) $display("[TB] FAIL full_drained: got %0b/%0d expected 1/0", empty, fill_level); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_in = 8'h40 + 8'(i);
            tick();
        end
        total_cnt++; if (full !== 1'b1) $display("[TB] FAIL b2b_full: got %0b expected 1", full); else pass_cnt++;
        rd_en = 1'b1;
        // The first simultaneous write hits a full FIFO and is dropped; later ones land.
        for (int k = 0; k < 8; k++) begin
            d_in = 8'h80 + 8'(k);
            tick();
            total_cnt++; if (dout !== 8'h40 + 8'(k)) $display("[TB] FAIL b2b_dout%0d: got %0h expected %0h", k, dout, 8'h40 + 8'(k)); else pass_cnt++;
            total_cnt++; if (fill_level !== 5'd15) $display("[TB] FAIL b2b_fill%0d: got %0d expected 15", k, fill_level); else pass_cnt++;
        end
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_v = (i < 8) ? 8'h48 + 8'(i) : 8'h81 + 8'(i - 8);
            total_cnt++; if (dout !== exp_v) $display("[TB] FAIL b2b_drain%0d: got %0h expected %0h", i, dout, exp_v); else pass_cnt++;
        end
        rd_en = 1'b0;
        tick();
        total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL b2b_empty: got %0b expected 1", empty); else pass_cnt++;
    endtask

    task automatic test_soft_reset();
        logic [7:0] words [5];
        words = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_in = words[i];
            tick();
        end
        wr_en = 1'b0;
        total_cnt++; if (fill_level !== 5'd5) $display("[TB] FAIL srst_fill_pre: got %0d expected 5", fill_level); else pass_cnt++;
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        total_cnt++; if (dout !== 8'h11 || pkt_done !== 1'b0) $display("[TB] FAIL srst_half: got %0h/%0b expected 11/0", dout, pkt_done); else pass_cnt++;
        soft_rst = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        d_in = 8'h99;
        tick();
        soft_rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        total_cnt++; if (empty !== 1'b1 || fill_level !== 5'd0) $display("[TB] FAIL srst_empty: got %0b/%0d expected 1/0", empty, fill_level); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00 || dout_valid !== 1'b0) $display("[TB] FAIL srst_dout: got %0h/%0b expected 0/0", dout, dout_valid); else pass_cnt++;
        // An orphan word would complete the old packet if the count survived the flush.
        wr_en = 1'b1;
        d_in = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++; if (dout !== 8'h55 || dout_valid !== 1'b1 || pkt_done !== 1'b0) $display("[TB] FAIL srst_orphan: got %0h/%0b/%0b expected 55/1/0", dout, dout_valid, pkt_done); else pass_cnt++;
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        wr_en = 1'b1;
        d_in = 8'h00;
        tick();
        d_in = 8'h66;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        total_cnt++; if (dout !== 8'h00 || pkt_done !== 1'b0) $display("[TB] FAIL srst_new_hdr: got %0h/%0b expected 0/0", dout, pkt_done); else pass_cnt++;
        tick();
        total_cnt++; if (dout !== 8'h66 || pkt_done !== 1'b1) $display("[TB] FAIL srst_new_done: got %0h/%0b expected 66/1", dout, pkt_done); else pass_cnt++;
        rd_en = 1'b0;
        tick();
        total_cnt++; if (pkt_done !== 1'b0) $display("[TB] FAIL srst_done_pulse: got %0b expected 0", pkt_done); else pass_cnt++;
    endtask

`ifdef ROUTER_FIFO_ERR_EN
    task automatic test_err();
        total_cnt++; if (err !== 1'b0) $display("[TB] FAIL err_clear: got %0b expected 0", err); else pass_cnt++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++; if (err !== 1'b1) $display("[TB] FAIL err_set: got %0b expected 1", err); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %0b expected 1", err); else pass_cnt++;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        total_cnt++; if (err !== 1'b0) $display("[TB] FAIL err_srst: got %0b expected 0", err); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_soft_reset();
`ifdef ROUTER_FIFO_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
